proc_fetch_queue: RTL and testbench

Parametrised fetch unit with prefetch buffering. It generates in-order instruction-fetch requests against a memory with variable latency and a valid/ready request handshake. Returned instructions are held in a DEPTH-entry queue tagged with their PC and PC+PC_INC. The queue supports decode backpressure, a halt input, and redirect (branch/jump) with flush of queued and in-flight fetches. It sits between the PC source and decode.

---
 rtl/proc_fetch_queue.sv | 178 +++++++++++++++++
 tb/tb_proc_fetch_queue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch_queue.sv
// proc_fetch_queue
//   In-order instruction fetch unit with a DEPTH-entry prefetch queue.
//   Requests are issued at the fetch PC, and each accepted request allocates a
//   queue entry. Responses come back in request order and fill entries in
//   allocation order. Decode pops filled entries from the head. A redirect
//   flushes the queue and marks every in-flight response for discard.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   redirect, redirect_pc   flush and restart fetch at redirect_pc
//   halt                suppress new requests (queue still drains)
//   mem_req_valid/ready/addr   fetch request handshake
//   mem_rsp_valid/data  in-order instruction return
//   out_valid/ready     head-of-queue handshake toward decode
//   out_instr, out_pc, out_incpc   head instruction, its PC and PC+PC_INC
//   err                 sticky: a response arrived with nothing outstanding
module proc_fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_incpc,
    output logic              err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] INC_C = ADDR_W'(PC_INC);

    // Architectural state
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              err_q, err_d;
    logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]  head_ptr_q, head_ptr_d;
    logic [DEPTH-1:0]  filled_q, filled_d;

    // Entry payload storage; contents are don't-care until filled
    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] instr_q [DEPTH];

    logic              req_fire;
    logic              pop_fire;
    logic              rsp_taken;   // response matched against an outstanding request
    logic              rsp_fill;    // response actually written into the queue
    logic [CNT_W-1:0]  outst_after_rsp;

    // Requests are gated by rst so nothing is presented while reset is held.
    assign mem_req_valid = rst && !halt && !redirect && (cnt_q < DEPTH_C) && (drop_q == '0);
    assign mem_req_addr  = fpc_q;

    assign out_valid = filled_q[head_ptr_q];
    assign out_instr = instr_q[head_ptr_q];
    assign out_pc    = pc_q[head_ptr_q];
    assign out_incpc = pc_q[head_ptr_q] + INC_C;
    assign err       = err_q;

    assign req_fire  = mem_req_valid && mem_req_ready;
    assign pop_fire  = out_valid && out_ready;
    assign rsp_taken = mem_rsp_valid && (outst_q != '0);
    // A response in a redirect cycle is always thrown away.
    assign rsp_fill  = rsp_taken && (drop_q == '0) && !redirect;

    assign outst_after_rsp = outst_q - CNT_W'(rsp_taken);

    // Per-entry filled flags: set by a fill, cleared by a pop, wiped by redirect.
    // A fill and a pop never target the same entry in one cycle: a filled head
    // with the fill pointer on it means every entry is filled and nothing is
    // outstanding.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic fill_here;
            logic pop_here;
            assign fill_here = rsp_fill && (fill_ptr_q == PTR_W'(gi));
            assign pop_here  = pop_fire && (head_ptr_q == PTR_W'(gi));
            assign filled_d[gi] = !redirect && ((filled_q[gi] && !pop_here) || fill_here);
        end
    endgenerate

    always_comb begin
        fpc_d       = fpc_q;
        cnt_d       = cnt_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        err_d       = err_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;

        if (mem_rsp_valid && (outst_q == '0)) begin
            err_d = 1'b1;
        end

        if (redirect) begin
            // Everything still in flight after this cycle's response must be
            // discarded before fetching resumes at the new PC.
            fpc_d       = redirect_pc;
            cnt_d       = '0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            outst_d     = outst_after_rsp;
            drop_d      = outst_after_rsp;
        end else begin
            if (req_fire) begin
                fpc_d       = fpc_q + INC_C;
                alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
            end
            if (rsp_taken && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (rsp_fill) begin
                fill_ptr_d = fill_ptr_q + PTR_W'(1);
            end
            if (pop_fire) begin
                head_ptr_d = head_ptr_q + PTR_W'(1);
            end
            cnt_d   = cnt_q + CNT_W'(req_fire) - CNT_W'(pop_fire);
            outst_d = outst_after_rsp + CNT_W'(req_fire);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q       <= RESET_PC;
            cnt_q       <= '0;
            outst_q     <= '0;
            drop_q      <= '0;
            err_q       <= 1'b0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            filled_q    <= '0;
        end else begin
            fpc_q       <= fpc_d;
            cnt_q       <= cnt_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            filled_q    <= filled_d;
        end
    end

    // Payload writes need no reset; validity is carried by filled_q.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_q[alloc_ptr_q] <= fpc_q;
        end
        if (rsp_fill) begin
            instr_q[fill_ptr_q] <= mem_rsp_data;
        end
    end

endmodule

// File: tb/tb_proc_fetch_queue.sv
`timescale 1ns/1ps
module tb_proc_fetch_queue;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_incpc;
    logic          err;

    int n_pass  = 0;
    int n_total = 0;

    proc_fetch_queue #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_incpc(out_incpc), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- memory model and transaction logs ----------------
    typedef struct { logic [AW-1:0] addr; int due; } pend_t;
    typedef struct { logic [AW-1:0] pc; logic [AW-1:0] incpc; logic [DW-1:0] instr; int cy; } pop_t;

    int            lat    = 1;
    bit            inject = 1'b0;
    int            cyc    = 0;
    pend_t         pend[$];
    logic [AW-1:0] req_log[$];
    pop_t          pop_log[$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            pend.delete();
        end else begin
            if (mem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
            if (mem_req_valid && mem_req_ready) begin
                pend.push_back('{mem_req_addr, cyc + lat});
                req_log.push_back(mem_req_addr);
                $display("[%0t] req  addr=%h", $time, mem_req_addr);
            end
            if (out_valid && out_ready) begin
                pop_log.push_back('{out_pc, out_incpc, out_instr, cyc});
                $display("[%0t] pop  pc=%h incpc=%h instr=%h", $time, out_pc, out_incpc, out_instr);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
            mem_rsp_valid = 1'b0;
        end else if (inject) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 16'hDEAD;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
        end
    end

    // Log accessors return X when the entry does not exist, so a missing
    // transaction fails its comparison.
    function automatic logic [AW-1:0] req_addr(input int i);
        if (i < req_log.size()) return req_log[i];
        return 'x;
    endfunction
    function automatic logic [AW-1:0] pop_pc(input int i);
        if (i < pop_log.size()) return pop_log[i].pc;
        return 'x;
    endfunction
    function automatic logic [AW-1:0] pop_incpc(input int i);
        if (i < pop_log.size()) return pop_log[i].incpc;
        return 'x;
    endfunction
    function automatic logic [DW-1:0] pop_instr(input int i);
        if (i < pop_log.size()) return pop_log[i].instr;
        return 'x;
    endfunction
    function automatic int pop_cy(input int i);
        if (i < pop_log.size()) return pop_log[i].cy;
        return -1000;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns after a rising edge with rst just released.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; redirect = 1'b0; halt = 1'b0; mem_req_ready = 1'b1;
        out_ready = 1'b0; inject = 1'b0; lat = 1;
        step(2);
        req_log.delete();
        pop_log.delete();
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        step(2);
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_total++; if (mem_req_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", mem_req_addr); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        step(12);
        n_total++; if (req_log.size() !== 12) $display("FAIL stream_req_count: got %0d want 12", req_log.size()); else n_pass++;
        n_total++; if (pop_log.size() !== 10) $display("FAIL stream_pop_count: got %0d want 10", pop_log.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            logic [AW-1:0] pc_e;
            pc_e = AW'(2 * i);
            n_total++; if (req_addr(i) !== pc_e) $display("FAIL stream_req_addr[%0d]: got %h want %h", i, req_addr(i), pc_e); else n_pass++;
            n_total++; if (pop_pc(i) !== pc_e) $display("FAIL stream_out_pc[%0d]: got %h want %h", i, pop_pc(i), pc_e); else n_pass++;
            n_total++; if (pop_incpc(i) !== pc_e + 16'd2) $display("FAIL stream_out_incpc[%0d]: got %h want %h", i, pop_incpc(i), pc_e + 16'd2); else n_pass++;
            n_total++; if (pop_instr(i) !== mem_word(pc_e)) $display("FAIL stream_out_instr[%0d]: got %h want %h", i, pop_instr(i), mem_word(pc_e)); else n_pass++;
            n_total++; if (pop_cy(i) !== pop_cy(0) + i) $display("FAIL stream_rate[%0d]: got cycle %0d want %0d", i, pop_cy(i), pop_cy(0) + i); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        step(10);
        n_total++; if (req_log.size() !== 4) $display("FAIL bp_req_count: got %0d want 4", req_log.size()); else n_pass++;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL bp_req_valid_full: got %b want 0", mem_req_valid); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_pc !== 16'h0000) $display("FAIL bp_head_pc: got %h want 0000", out_pc); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL bp_req_before_pop: got %b want 0", mem_req_valid); else n_pass++;
        step(1);
        n_total++; if (mem_req_valid !== 1'b1) $display("FAIL bp_req_after_pop: got %b want 1", mem_req_valid); else n_pass++;
        n_total++; if (mem_req_addr !== 16'h0008) $display("FAIL bp_resume_addr: got %h want 0008", mem_req_addr); else n_pass++;
        step(6);
        for (int i = 0; i < 4; i++) begin
            n_total++; if (pop_pc(i) !== AW'(2 * i)) $display("FAIL bp_pop_pc[%0d]: got %h want %h", i, pop_pc(i), AW'(2 * i)); else n_pass++;
        end
        n_total++; if (req_addr(4) !== 16'h0008) $display("FAIL bp_req4: got %h want 0008", req_addr(4)); else n_pass++;
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        lat = 3;
        out_ready = 1'b1;
        step(2);                         // requests to 0 and 2 in flight
        mem_req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL redir_req_in_redirect: got %b want 0", mem_req_valid); else n_pass++;
        step(1);
        redirect = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL redir_req_drop2: got %b want 0", mem_req_valid); else n_pass++;
        step(1);
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL redir_req_drop1: got %b want 0", mem_req_valid); else n_pass++;
        step(1);
        n_total++; if (mem_req_valid !== 1'b1) $display("FAIL redir_req_resume: got %b want 1", mem_req_valid); else n_pass++;
        n_total++; if (mem_req_addr !== 16'h0100) $display("FAIL redir_req_addr: got %h want 0100", mem_req_addr); else n_pass++;
        step(8);
        n_total++; if (req_addr(2) !== 16'h0100) $display("FAIL redir_req_log: got %h want 0100", req_addr(2)); else n_pass++;
        n_total++; if (pop_pc(0) !== 16'h0100) $display("FAIL redir_first_pc: got %h want 0100", pop_pc(0)); else n_pass++;
        n_total++; if (pop_instr(0) !== mem_word(16'h0100)) $display("FAIL redir_first_instr: got %h want %h", pop_instr(0), mem_word(16'h0100)); else n_pass++;
        n_total++; if (pop_pc(1) !== 16'h0102) $display("FAIL redir_second_pc: got %h want 0102", pop_pc(1)); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL redir_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        lat = 2;
        out_ready = 1'b1;
        step(4);
        // This cycle: head pc 2 popping, response for pc 4 arriving, pc 6 still out.
        n_total++; if (out_valid !== 1'b1) $display("FAIL simul_pre_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_pc !== 16'h0002) $display("FAIL simul_pre_pc: got %h want 0002", out_pc); else n_pass++;
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        step(1);
        redirect = 1'b0;
        #1;
        n_total++; if (pop_log.size() !== 2) $display("FAIL simul_pop_count: got %0d want 2", pop_log.size()); else n_pass++;
        n_total++; if (pop_pc(1) !== 16'h0002) $display("FAIL simul_pop_pc: got %h want 0002", pop_pc(1)); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL simul_empty: got %b want 0", out_valid); else n_pass++;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL simul_drop1_req: got %b want 0", mem_req_valid); else n_pass++;
        step(1);
        n_total++; if (mem_req_valid !== 1'b1) $display("FAIL simul_resume_req: got %b want 1", mem_req_valid); else n_pass++;
        n_total++; if (mem_req_addr !== 16'h0200) $display("FAIL simul_resume_addr: got %h want 0200", mem_req_addr); else n_pass++;
        step(6);
        n_total++; if (req_addr(4) !== 16'h0200) $display("FAIL simul_req_log: got %h want 0200", req_addr(4)); else n_pass++;
        n_total++; if (pop_pc(2) !== 16'h0200) $display("FAIL simul_next_pc: got %h want 0200", pop_pc(2)); else n_pass++;
    endtask

    task automatic test_wrap_halt();
        do_reset();
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        step(1);
        redirect = 1'b0;
        #1;
        n_total++; if (mem_req_addr !== 16'hFFFE) $display("FAIL wrap_req_addr: got %h want fffe", mem_req_addr); else n_pass++;
        step(1);                         // request to FFFE accepted
        halt = 1'b1;
        #1;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL halt_req_valid: got %b want 0", mem_req_valid); else n_pass++;
        step(5);
        n_total++; if (req_log.size() !== 1) $display("FAIL halt_req_count: got %0d want 1", req_log.size()); else n_pass++;
        n_total++; if (pop_pc(0) !== 16'hFFFE) $display("FAIL wrap_out_pc: got %h want fffe", pop_pc(0)); else n_pass++;
        n_total++; if (pop_incpc(0) !== 16'h0000) $display("FAIL wrap_out_incpc: got %h want 0000", pop_incpc(0)); else n_pass++;
        halt = 1'b0;
        #1;
        n_total++; if (mem_req_valid !== 1'b1) $display("FAIL unhalt_req_valid: got %b want 1", mem_req_valid); else n_pass++;
        n_total++; if (mem_req_addr !== 16'h0000) $display("FAIL unhalt_req_addr: got %h want 0000", mem_req_addr); else n_pass++;
        step(4);
        n_total++; if (pop_pc(1) !== 16'h0000) $display("FAIL unhalt_pop_pc: got %h want 0000", pop_pc(1)); else n_pass++;
        n_total++; if (pop_incpc(1) !== 16'h0002) $display("FAIL unhalt_pop_incpc: got %h want 0002", pop_incpc(1)); else n_pass++;
    endtask

    task automatic test_err_async_reset();
        do_reset();
        halt = 1'b1;
        step(2);
        n_total++; if (err !== 1'b0) $display("FAIL err_initial: got %b want 0", err); else n_pass++;
        inject = 1'b1;                   // response with nothing outstanding
        step(1);
        inject = 1'b0;
        n_total++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else n_pass++;
        step(3);
        n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
        halt = 1'b0;
        out_ready = 1'b1;
        step(6);
        n_total++; if (err !== 1'b1) $display("FAIL err_sticky_stream: got %b want 1", err); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL stream_before_rst: got %b want 1", out_valid); else n_pass++;
        #2;                              // between clock edges
        rst = 1'b0;
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL async_err: got %b want 0", err); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL async_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL async_req_valid: got %b want 0", mem_req_valid); else n_pass++;
        @(posedge clk); #1;
        req_log.delete();
        pop_log.delete();
        rst = 1'b1;
        #1;
        n_total++; if (mem_req_valid !== 1'b1) $display("FAIL restart_req_valid: got %b want 1", mem_req_valid); else n_pass++;
        n_total++; if (mem_req_addr !== 16'h0000) $display("FAIL restart_addr: got %h want 0000", mem_req_addr); else n_pass++;
        step(4);
        n_total++; if (req_addr(0) !== 16'h0000) $display("FAIL restart_req_log: got %h want 0000", req_addr(0)); else n_pass++;
        n_total++; if (pop_pc(0) !== 16'h0000) $display("FAIL restart_pop_pc: got %h want 0000", pop_pc(0)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_simultaneous();
        test_wrap_halt();
        test_err_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
